// File: rtl/msix_irq_sender_if.sv
// rtl/msix_irq_sender_if.sv - MSI-X TX/RX response channels and DMA write request stream
interface msix_irq_sender_if #(
    parameter int HEAD_WIDTH     = 128,
    parameter int IRQ_MSG        = 32,
    parameter int DMA_ADDR_WIDTH = 64
);
    // TX interrupt-response channel
    logic [IRQ_MSG-1:0]        tx_irq_rsp_msg;
    logic [DMA_ADDR_WIDTH-1:0] tx_irq_rsp_addr;
    logic                      tx_irq_rsp_valid;
    logic                      tx_irq_rsp_ready;

    // RX interrupt-response channel
    logic [IRQ_MSG-1:0]        rx_irq_rsp_msg;
    logic [DMA_ADDR_WIDTH-1:0] rx_irq_rsp_addr;
    logic                      rx_irq_rsp_valid;
    logic                      rx_irq_rsp_ready;

    // Single-beat DMA memory-write request
    logic                      irq_axis_valid;
    logic                      irq_axis_last;
    logic [HEAD_WIDTH-1:0]     irq_axis_head;
    logic [IRQ_MSG-1:0]        irq_axis_data;
    logic                      irq_axis_ready;

    // Interrupt sender view
    modport master (
        input  tx_irq_rsp_msg, tx_irq_rsp_addr, tx_irq_rsp_valid,
        output tx_irq_rsp_ready,
        input  rx_irq_rsp_msg, rx_irq_rsp_addr, rx_irq_rsp_valid,
        output rx_irq_rsp_ready,
        output irq_axis_valid, irq_axis_last, irq_axis_head, irq_axis_data,
        input  irq_axis_ready
    );

    // MSI-X manager / DMA engine view
    modport slave (
        output tx_irq_rsp_msg, tx_irq_rsp_addr, tx_irq_rsp_valid,
        input  tx_irq_rsp_ready,
        output rx_irq_rsp_msg, rx_irq_rsp_addr, rx_irq_rsp_valid,
        input  rx_irq_rsp_ready,
        input  irq_axis_valid, irq_axis_last, irq_axis_head, irq_axis_data,
        output irq_axis_ready
    );
endinterface

// File: rtl/msix_irq_sender.sv
// rtl/msix_irq_sender.sv - round-robin MSI-X response arbiter emitting DMA interrupt writes
module msix_irq_sender #(
    parameter int HEAD_WIDTH     = 128,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      irq_en,
    msix_irq_sender_if.master         bus,
    output logic [31:0]               irq_sent_cnt,
    output logic [DROP_CNT_WIDTH-1:0] irq_drop_cnt
);
    localparam int IRQ_MSG        = 32;
    localparam int DMA_ADDR_WIDTH = 64;
    localparam logic [31:0] IRQ_OPCODE = 32'h2;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic                      last_rx_q;
    logic [IRQ_MSG-1:0]        msg_q;
    logic [DMA_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               sent_cnt_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

    logic                      cand_tx;
    logic                      cand_rx;
    logic                      grant_tx;
    logic                      grant_rx;
    logic                      grant;
    logic [IRQ_MSG-1:0]        sel_msg;
    logic [DMA_ADDR_WIDTH-1:0] sel_addr;
    logic                      sel_bad;
    logic                      inc_sent;
    logic                      inc_drop;
    logic                      send_active;

    // Round-robin pick between the two channels; grants only happen in IDLE
    always_comb begin
        cand_tx  = irq_en && bus.tx_irq_rsp_valid;
        cand_rx  = irq_en && bus.rx_irq_rsp_valid;
        grant_tx = 1'b0;
        grant_rx = 1'b0;
        if (state_q == IDLE) begin
            // On a tie the channel that did not win last time goes first
            grant_tx = cand_tx && (!cand_rx || last_rx_q);
            grant_rx = cand_rx && (!cand_tx || !last_rx_q);
        end
        grant    = grant_tx || grant_rx;
        sel_msg  = grant_rx ? bus.rx_irq_rsp_msg  : bus.tx_irq_rsp_msg;
        sel_addr = grant_rx ? bus.rx_irq_rsp_addr : bus.tx_irq_rsp_addr;
        // Zero means the vector was never programmed; DWORD misalignment is unusable
        sel_bad  = (sel_addr == '0) || (sel_addr[1:0] != 2'b00);
    end

    // Ready is the grant itself, forced low while reset is held
    assign bus.tx_irq_rsp_ready = rst_n && grant_tx;
    assign bus.rx_irq_rsp_ready = rst_n && grant_rx;

    // Next-state decision and counter increment requests
    always_comb begin
        state_d  = state_q;
        inc_sent = 1'b0;
        inc_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    if (sel_bad) begin
                        inc_drop = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.irq_axis_ready) begin
                    inc_sent = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted response and remember which channel won
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rx_q <= 1'b1;
            msg_q     <= '0;
            addr_q    <= '0;
        end else if (grant) begin
            last_rx_q <= grant_rx;
            msg_q     <= sel_msg;
            addr_q    <= sel_addr;
        end
    end

    // Sent counter wraps; drop counter sticks at its maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (inc_sent) begin
                sent_cnt_q <= sent_cnt_q + 32'd1;
            end
            if (inc_drop && (drop_cnt_q != DROP_MAX)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign send_active        = (state_q == SEND);
    assign bus.irq_axis_valid = send_active;
    assign bus.irq_axis_last  = send_active;
    assign bus.irq_axis_head  = send_active ? HEAD_WIDTH'({IRQ_OPCODE, addr_q, 32'h0}) : '0;
    assign bus.irq_axis_data  = send_active ? msg_q : '0;

    assign irq_sent_cnt = sent_cnt_q;
    assign irq_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_msix_irq_sender.sv
// tb/tb_msix_irq_sender.sv - self-checking bench for msix_irq_sender
module tb_msix_irq_sender;
    localparam int HEAD_WIDTH = 128;
    localparam int DROP_MAX   = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_en;
    logic        sat_en;
    logic [31:0] sent_cnt;
    logic [15:0] drop_cnt;
    logic [31:0] sat_sent;
    logic [2:0]  sat_drop;

    msix_irq_sender_if #(.HEAD_WIDTH(HEAD_WIDTH)) bus ();
    msix_irq_sender_if #(.HEAD_WIDTH(HEAD_WIDTH)) sat_bus ();

    msix_irq_sender #(.HEAD_WIDTH(HEAD_WIDTH), .DROP_CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_en       (irq_en),
        .bus          (bus.master),
        .irq_sent_cnt (sent_cnt),
        .irq_drop_cnt (drop_cnt)
    );

    msix_irq_sender #(.HEAD_WIDTH(HEAD_WIDTH), .DROP_CNT_WIDTH(3)) sat_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_en       (sat_en),
        .bus          (sat_bus.master),
        .irq_sent_cnt (sat_sent),
        .irq_drop_cnt (sat_drop)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: is a request pending, what is it, who won last, counts
    bit          m_busy;
    logic [31:0] m_msg;
    logic [63:0] m_addr;
    bit          m_last_rx;
    logic [31:0] m_sent;
    int          m_drop;

    bit          n_busy;
    logic [31:0] n_msg;
    logic [63:0] n_addr;
    bit          n_last_rx;
    logic [31:0] n_sent;
    int          n_drop;

    bit          last_gtx;
    bit          last_grx;
    string       glog;

    logic         cap_tx_ready, cap_rx_ready, cap_valid, cap_last;
    logic [127:0] cap_head;
    logic [31:0]  cap_data, cap_sent;
    logic [15:0]  cap_drop;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_msg = '0; m_addr = '0; m_last_rx = 1; m_sent = '0; m_drop = 0;
        last_gtx = 0; last_grx = 0;
    endtask

    // Runs at the falling edge: compare DUT against model, work out next model state
    task automatic compare_cycle();
        bit ctx, crx, gtx, grx;
        logic [127:0] exp_head;
        logic [63:0]  a;
        logic [31:0]  m;
        ctx = irq_en && bus.tx_irq_rsp_valid;
        crx = irq_en && bus.rx_irq_rsp_valid;
        gtx = 0;
        grx = 0;
        if (!m_busy) begin
            if (ctx && crx) begin
                if (m_last_rx) gtx = 1; else grx = 1;
            end else if (ctx) gtx = 1;
            else if (crx) grx = 1;
        end
        exp_head = m_busy ? {32'h2, m_addr, 32'h0} : 128'h0;

        cap_tx_ready = bus.tx_irq_rsp_ready;
        cap_rx_ready = bus.rx_irq_rsp_ready;
        cap_valid    = bus.irq_axis_valid;
        cap_last     = bus.irq_axis_last;
        cap_head     = bus.irq_axis_head;
        cap_data     = bus.irq_axis_data;
        cap_sent     = sent_cnt;
        cap_drop     = drop_cnt;

        chk("tx_ready", 128'(cap_tx_ready), 128'(gtx));
        chk("rx_ready", 128'(cap_rx_ready), 128'(grx));
        chk("axis_valid", 128'(cap_valid), 128'(m_busy));
        chk("axis_last", 128'(cap_last), 128'(m_busy));
        chk("axis_head", cap_head, exp_head);
        chk("axis_data", 128'(cap_data), 128'(m_busy ? m_msg : 32'h0));
        chk("sent_cnt", 128'(cap_sent), 128'(m_sent));
        chk("drop_cnt", 128'(cap_drop), 128'(m_drop));

        if (cap_tx_ready) glog = {glog, "T"};
        if (cap_rx_ready) glog = {glog, "R"};

        n_busy = m_busy; n_msg = m_msg; n_addr = m_addr;
        n_last_rx = m_last_rx; n_sent = m_sent; n_drop = m_drop;
        if (m_busy) begin
            if (bus.irq_axis_ready) begin
                n_busy = 0;
                n_sent = m_sent + 32'd1;
            end
        end else if (gtx || grx) begin
            n_last_rx = grx;
            a = grx ? bus.rx_irq_rsp_addr : bus.tx_irq_rsp_addr;
            m = grx ? bus.rx_irq_rsp_msg  : bus.tx_irq_rsp_msg;
            if (a == 64'h0 || a[1:0] != 2'b00) begin
                n_drop = (m_drop >= DROP_MAX) ? DROP_MAX : m_drop + 1;
            end else begin
                n_busy = 1; n_msg = m; n_addr = a;
            end
        end
        last_gtx = gtx;
        last_grx = grx;
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        m_busy = n_busy; m_msg = n_msg; m_addr = n_addr;
        m_last_rx = n_last_rx; m_sent = n_sent; m_drop = n_drop;
    endtask

    task automatic set_tx(input logic v, input logic [31:0] msg, input logic [63:0] addr);
        bus.tx_irq_rsp_valid = v; bus.tx_irq_rsp_msg = msg; bus.tx_irq_rsp_addr = addr;
    endtask

    task automatic set_rx(input logic v, input logic [31:0] msg, input logic [63:0] addr);
        bus.rx_irq_rsp_valid = v; bus.rx_irq_rsp_msg = msg; bus.rx_irq_rsp_addr = addr;
    endtask

    task automatic rand_req(output logic [31:0] msg, output logic [63:0] addr);
        int k;
        k = $urandom_range(0, 9);
        msg = $urandom;
        if (k == 0) addr = 64'h0;
        else if (k == 1) addr = {32'($urandom), 30'($urandom), 2'($urandom_range(1, 3))};
        else begin
            addr = {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
            if (addr == 64'h0) addr = 64'h4;
        end
    endtask

    initial begin
        logic [31:0] rm;
        logic [63:0] ra;
        rst_n = 0; irq_en = 0; sat_en = 0;
        set_tx(0, '0, '0);
        set_rx(0, '0, '0);
        bus.irq_axis_ready = 0;
        sat_bus.tx_irq_rsp_valid = 0; sat_bus.tx_irq_rsp_msg = '0; sat_bus.tx_irq_rsp_addr = '0;
        sat_bus.rx_irq_rsp_valid = 1; sat_bus.rx_irq_rsp_msg = 32'h5; sat_bus.rx_irq_rsp_addr = '0;
        sat_bus.irq_axis_ready = 1;
        model_reset();
        glog = "";

        // Reset state
        @(negedge clk);
        chk("rst_tx_ready", 128'(bus.tx_irq_rsp_ready), 128'h0);
        chk("rst_rx_ready", 128'(bus.rx_irq_rsp_ready), 128'h0);
        chk("rst_valid", 128'(bus.irq_axis_valid), 128'h0);
        chk("rst_last", 128'(bus.irq_axis_last), 128'h0);
        chk("rst_head", bus.irq_axis_head, 128'h0);
        chk("rst_data", 128'(bus.irq_axis_data), 128'h0);
        chk("rst_sent", 128'(sent_cnt), 128'h0);
        chk("rst_drop", 128'(drop_cnt), 128'h0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();

        // Tie arbitration: TX first after reset, then alternate
        irq_en = 1; bus.irq_axis_ready = 1;
        set_tx(1, 32'h11, 64'h0000_0000_0000_A000);
        set_rx(1, 32'h22, 64'h0000_0000_0000_B000);
        glog = "";
        repeat (8) step();
        set_tx(0, '0, '0);
        set_rx(0, '0, '0);
        chk("tie_order", 128'(glog == "TRTR"), 128'h1);
        step();
        chk("tie_sent", 128'(cap_sent), 128'd4);

        // Single TX send
        set_tx(1, 32'h0000_0041, 64'h0000_0000_FEE0_1000);
        step();
        chk("single_tx_ready", 128'(cap_tx_ready), 128'h1);
        set_tx(0, '0, '0);
        step();
        chk("single_valid", 128'(cap_valid), 128'h1);
        chk("single_last", 128'(cap_last), 128'h1);
        chk("single_head", cap_head, {32'h2, 64'h0000_0000_FEE0_1000, 32'h0});
        chk("single_data", 128'(cap_data), 128'h41);
        step();
        chk("single_sent", 128'(cap_sent), 128'd5);

        // Back-pressure: hold for 10 cycles with RX waiting behind
        bus.irq_axis_ready = 0;
        set_tx(1, 32'h55, 64'h2000);
        step();
        set_tx(0, '0, '0);
        set_rx(1, 32'h66, 64'h2100);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 128'(cap_valid), 128'h1);
            chk("bp_tx_ready", 128'(cap_tx_ready), 128'h0);
            chk("bp_rx_ready", 128'(cap_rx_ready), 128'h0);
            chk("bp_head", cap_head, {32'h2, 64'h2000, 32'h0});
            chk("bp_data", 128'(cap_data), 128'h55);
        end
        bus.irq_axis_ready = 1;
        step();
        chk("bp_deliver_valid", 128'(cap_valid), 128'h1);
        step();
        chk("bp_next_rx_grant", 128'(cap_rx_ready), 128'h1);
        set_rx(0, '0, '0);
        step();
        step();
        chk("bp_sent", 128'(cap_sent), 128'd7);

        // Drops: unprogrammed and misaligned RX vectors
        set_rx(1, 32'h1, 64'h0);
        step();
        chk("drop0_ready", 128'(cap_rx_ready), 128'h1);
        set_rx(1, 32'h2, 64'h1002);
        step();
        chk("drop1_ready", 128'(cap_rx_ready), 128'h1);
        chk("drop1_valid", 128'(cap_valid), 128'h0);
        set_rx(0, '0, '0);
        step();
        chk("drop_valid", 128'(cap_valid), 128'h0);
        chk("drop_cnt2", 128'(cap_drop), 128'd2);
        chk("drop_sent", 128'(cap_sent), 128'd7);

        // Enable gating
        irq_en = 0;
        set_tx(1, 32'h77, 64'h3000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en_off_ready", 128'(cap_tx_ready), 128'h0);
        end
        irq_en = 1;
        step();
        chk("en_on_ready", 128'(cap_tx_ready), 128'h1);
        set_tx(0, '0, '0);
        irq_en = 0;
        step();
        chk("en_off_send_valid", 128'(cap_valid), 128'h1);
        step();
        chk("en_off_sent", 128'(cap_sent), 128'd8);
        irq_en = 1;

        // Reset while a send is pending; last grant before reset is TX
        bus.irq_axis_ready = 0;
        set_tx(1, 32'h88, 64'h4000);
        step();
        set_rx(1, 32'h99, 64'h4100);
        step();
        rst_n = 0;
        #1;
        chk("rstm_valid", 128'(bus.irq_axis_valid), 128'h0);
        chk("rstm_last", 128'(bus.irq_axis_last), 128'h0);
        chk("rstm_head", bus.irq_axis_head, 128'h0);
        chk("rstm_data", 128'(bus.irq_axis_data), 128'h0);
        chk("rstm_tx_ready", 128'(bus.tx_irq_rsp_ready), 128'h0);
        chk("rstm_rx_ready", 128'(bus.rx_irq_rsp_ready), 128'h0);
        chk("rstm_sent", 128'(sent_cnt), 128'h0);
        chk("rstm_drop", 128'(drop_cnt), 128'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        bus.irq_axis_ready = 1;
        step();
        chk("rstm_tie_tx", 128'(cap_tx_ready), 128'h1);
        chk("rstm_tie_rx", 128'(cap_rx_ready), 128'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            irq_en = ($urandom_range(0, 9) != 0);
            bus.irq_axis_ready = ($urandom_range(0, 9) < 7);
            if (last_gtx || !bus.tx_irq_rsp_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    rand_req(rm, ra);
                    set_tx(1, rm, ra);
                end else set_tx(0, '0, '0);
            end
            if (last_grx || !bus.rx_irq_rsp_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    rand_req(rm, ra);
                    set_rx(1, rm, ra);
                end else set_rx(0, '0, '0);
            end
            step();
        end

        // Drop counter saturation on a narrow instance
        sat_en = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("sat_drop", 128'(sat_drop), 128'((i > 7) ? 7 : i));
            chk("sat_valid", 128'(sat_bus.irq_axis_valid), 128'h0);
            @(posedge clk); #1;
        end
        chk("sat_sent", 128'(sat_sent), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
